// File: rtl/alu_dec_count_unit.sv
// Datapath utility block: combinational 4-bit ALU with flags, 3-to-8 one-hot
// decoder with enable, and a 3-bit enabled down-counter with synchronous reset.
module alu_dec_count_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] alu_fnselec,
  input  logic [3:0] alu_a,
  input  logic [3:0] alu_b,
  output logic [3:0] alu_res,
  output logic       alu_zero,
  output logic       alu_overflow,
  output logic       alu_carry,
  input  logic [2:0] x,
  input  logic       en,
  output logic [7:0] y_dec,
  input  logic       counter_en,
  output logic [2:0] dec_counter_out
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  // Five-bit sums so the carry-out falls out of bit 4; SUB is a + ~b + 1.
  logic [4:0] add_sum;
  logic [4:0] sub_sum;
  logic       add_ovf;
  logic       sub_ovf;
  logic       signed_lt;

  assign add_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign sub_sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
  assign add_ovf   = (alu_a[3] == alu_b[3]) && (add_sum[3] != alu_a[3]);
  assign sub_ovf   = (alu_a[3] != alu_b[3]) && (sub_sum[3] != alu_a[3]);
  assign signed_lt = sub_sum[3] ^ sub_ovf;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned, which would infer a latch.
    alu_res      = 4'b0000;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_fnselec)
      OP_ADD: begin
        alu_res      = add_sum[3:0];
        alu_carry    = add_sum[4];
        alu_overflow = add_ovf;
      end
      OP_SUB: begin
        alu_res      = sub_sum[3:0];
        alu_carry    = sub_sum[4];
        alu_overflow = sub_ovf;
      end
      OP_NOT:  alu_res = ~alu_a;
      OP_AND:  alu_res = alu_a & alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_XOR:  alu_res = alu_a ^ alu_b;
      OP_SLT:  alu_res = {3'b000, signed_lt};
      OP_EQ:   alu_res = {3'b000, alu_a == alu_b};
      default: alu_res = 4'b0000;
    endcase
  end

  assign alu_zero = (alu_res == 4'b0000);

  assign y_dec = en ? (8'b0000_0001 << x) : 8'h00;

  logic [2:0] count;

  // Reset wins over enable; the counter wraps 0 -> 7 naturally in 3 bits.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values, avoiding simulation races.
    if (rst)
      count <= 3'd7;
    else if (counter_en)
      count <= count - 3'd1;
  end

  assign dec_counter_out = count;

endmodule

// File: tb/tb_alu_dec_count_unit.sv
// Self-checking bench for alu_dec_count_unit: directed vector table, directed
// counter sequences, and randomized stimulus against an arithmetic model.
module tb_alu_dec_count_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_res;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry;
  logic [2:0] x;
  logic       en;
  logic [7:0] y_dec;
  logic       counter_en;
  logic [2:0] dec_counter_out;

  int tests_run = 0;
  int tests_failed = 0;

  alu_dec_count_unit dut (
    .clk             (clk),
    .rst             (rst),
    .alu_fnselec     (alu_fnselec),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_res         (alu_res),
    .alu_zero        (alu_zero),
    .alu_overflow    (alu_overflow),
    .alu_carry       (alu_carry),
    .x               (x),
    .en              (en),
    .y_dec           (y_dec),
    .counter_en      (counter_en),
    .dec_counter_out (dec_counter_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] fn;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       zero;
    logic       ovf;
    logic       carry;
  } alu_vec_t;

  alu_vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic on signed/unsigned values.
  task automatic model_alu(input int fn, input int a, input int b,
                           output int res, output int zero, output int ovf, output int carry);
    int sa, sb, s;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    res = 0; ovf = 0; carry = 0;
    case (fn)
      0: begin s = sa + sb; res = (a + b) % 16; carry = (a + b >= 16); ovf = (s > 7 || s < -8); end
      1: begin s = sa - sb; res = (a - b + 16) % 16; carry = (a >= b); ovf = (s > 7 || s < -8); end
      2: res = 15 - a;
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = (sa < sb) ? 1 : 0;
      default: res = (a == b) ? 1 : 0;
    endcase
    zero = (res == 0);
  endtask

  task automatic check_alu(input string tag, input logic [3:0] res, input logic zero,
                           input logic ovf, input logic carry);
    check({tag, " res"},   32'(alu_res),      32'(res));
    check({tag, " zero"},  32'(alu_zero),     32'(zero));
    check({tag, " ovf"},   32'(alu_overflow), 32'(ovf));
    check({tag, " carry"}, 32'(alu_carry),    32'(carry));
  endtask

  task automatic clock_step(input logic r, input logic e);
    @(negedge clk);
    rst = r;
    counter_en = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    int mr, mz, mo, mc;
    logic [2:0] seq [9];

    vecs[0]  = '{3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{3'b010, 4'b1010, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b011, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b101, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b110, 4'b1000, 4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b110, 4'b0111, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b111, 4'b0110, 4'b0110, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b111, 4'b0110, 4'b0111, 4'b0000, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; counter_en = 1'b0;
    alu_fnselec = '0; alu_a = '0; alu_b = '0; x = '0; en = 1'b0;

    // ALU directed table.
    foreach (vecs[i]) begin
      alu_fnselec = vecs[i].fn; alu_a = vecs[i].a; alu_b = vecs[i].b;
      #1;
      check_alu($sformatf("alu_vec%0d", i), vecs[i].res, vecs[i].zero, vecs[i].ovf, vecs[i].carry);
    end

    // Decoder sweep and disable.
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = 3'(i);
      #1;
      check($sformatf("dec_x%0d", i), 32'(y_dec), 32'(1 << i));
    end
    x = 3'd5; en = 1'b0;
    #1;
    check("dec_disabled", 32'(y_dec), 32'h0);

    // Counter: reset, 9 enabled edges, 3 held edges.
    clock_step(1'b1, 1'b0);
    check("cnt_reset", 32'(dec_counter_out), 32'd7);
    seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
    for (int i = 0; i < 9; i++) begin
      clock_step(1'b0, 1'b1);
      check($sformatf("cnt_run%0d", i), 32'(dec_counter_out), 32'(seq[i]));
    end
    for (int i = 0; i < 3; i++) begin
      clock_step(1'b0, 1'b0);
      check($sformatf("cnt_hold%0d", i), 32'(dec_counter_out), 32'd6);
    end

    // A rst pulse between edges must not disturb the count.
    @(negedge clk);
    rst = 1'b1; #2; rst = 1'b0; #1;
    check("cnt_rst_glitch_now", 32'(dec_counter_out), 32'd6);
    clock_step(1'b0, 1'b0);
    check("cnt_rst_glitch_edge", 32'(dec_counter_out), 32'd6);

    // Reset priority over enable at count 3.
    for (int i = 0; i < 3; i++) clock_step(1'b0, 1'b1);
    check("cnt_at3", 32'(dec_counter_out), 32'd3);
    clock_step(1'b1, 1'b1);
    check("cnt_rst_prio", 32'(dec_counter_out), 32'd7);
    clock_step(1'b0, 1'b1);
    check("cnt_resume", 32'(dec_counter_out), 32'd6);

    // Randomized: all three sub-functions against the model each cycle.
    exp_cnt = 6;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      alu_fnselec = 3'($urandom_range(0, 7));
      alu_a = 4'($urandom_range(0, 15));
      alu_b = 4'($urandom_range(0, 15));
      x = 3'($urandom_range(0, 7));
      en = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 15) == 0);
      counter_en = 1'($urandom_range(0, 1));
      #1;
      model_alu(int'(alu_fnselec), int'(alu_a), int'(alu_b), mr, mz, mo, mc);
      check_alu($sformatf("rnd%0d_fn%0d", i, alu_fnselec), 4'(mr), 1'(mz), 1'(mo), 1'(mc));
      check($sformatf("rnd%0d_dec", i), 32'(y_dec), en ? 32'(1 << x) : 32'h0);
      if (rst) exp_cnt = 7;
      else if (counter_en) exp_cnt = (exp_cnt + 7) % 8;
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_cnt", i), 32'(dec_counter_out), 32'(exp_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
